// File: rtl/wbdbgbus_pkg.sv
// Shared debug-bus definitions: command widths, the assembled command
// layout, the executor opcode set and the assembler byte-index states.
package wbdbgbus_pkg;

  localparam int CMD_W         = 36;
  localparam int OPC_W         = 4;
  localparam int DATA_W        = 32;
  localparam int BYTES_PER_CMD = 5;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [31:0] data;
  } wbdbgbus_cmd_t;

  typedef enum logic [3:0] {
    OPC_NOP      = 4'h0,
    OPC_SET_ADDR = 4'h1,
    OPC_READ     = 4'h2,
    OPC_WRITE    = 4'h3,
    OPC_SET_INCR = 4'h4,
    OPC_RESET    = 4'hF
  } wbdbgbus_opcode_e;

  // Byte index of the command being assembled; the name tells which
  // field the next accepted byte lands in.
  typedef enum logic [2:0] {
    IDX_OPC = 3'd0,
    IDX_D3  = 3'd1,
    IDX_D2  = 3'd2,
    IDX_D1  = 3'd3,
    IDX_D0  = 3'd4
  } byte_idx_e;

endpackage

// File: rtl/wbdbgbus_gap_timer.sv
// Clearable saturating idle counter. o_expire is high for the single cycle
// in which the count equals LIMIT-1; the count then parks at LIMIT until
// cleared, so it never wraps.
module wbdbgbus_gap_timer #(
  parameter int LIMIT = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_expire
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count idle cycles, clear on request, hold at LIMIT.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_expire = (cnt_q == CNT_EXP);

endmodule

// File: rtl/wbdbgbus_cmd_assembler.sv
// Debug-bus command assembler: packs five UART bytes (opcode, then data
// MSB first) into one 36-bit command on a valid/ready output.
// Optional inter-byte gap timer: define WBDBGBUS_CMD_TIMEOUT_EN.
//
// state   | meaning
// IDX_OPC | idle, next byte is the opcode (low nibble kept)
// IDX_D3  | next byte is data[31:24]
// IDX_D2  | next byte is data[23:16]
// IDX_D1  | next byte is data[15:8]
// IDX_D0  | next byte is data[7:0], completes the command
module wbdbgbus_cmd_assembler
  import wbdbgbus_pkg::*;
#(
  parameter int CLK_FREQ     = 250000,
  parameter int BAUD         = 9600,
  parameter int TIMEOUT_CLKS = 20 * (CLK_FREQ / BAUD)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic [CMD_W-1:0]  o_cmd,
  output logic              o_cmd_valid,
  input  logic              i_cmd_ready,
  output logic              o_busy,
  output logic              o_overflow,
  output logic              o_timeout
);

  if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
    $error("TIMEOUT_CLKS must be at least 2");
  end

  byte_idx_e     state_q, state_d;
  logic          take_opc, take_data, complete;
  logic          rx_expire;
  logic          cmd_free;
  logic [3:0]    opcode_q;
  logic [23:0]   data_q;   // first three data bytes; the last goes straight to o_cmd
  wbdbgbus_cmd_t cmd_q;
  logic          cmd_valid_q, busy_q, ovf_q;

`ifdef WBDBGBUS_CMD_TIMEOUT_EN
  logic timer_expire;
  logic to_q;

  wbdbgbus_gap_timer #(
    .LIMIT (TIMEOUT_CLKS)
  ) u_gap_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (i_rx_valid || (state_q == IDX_OPC)),
    .o_expire (timer_expire)
  );

  assign rx_expire = timer_expire && (state_q != IDX_OPC);

  // Register the expiry into a one-cycle timeout pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) to_q <= 1'b0;
    else       to_q <= rx_expire;
  end

  assign o_timeout = to_q;
`else
  assign rx_expire = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // Byte-index state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDX_OPC;
    else       state_q <= state_d;
  end

  // Next byte index and byte steering; an expiry restarts the command and
  // a byte arriving in that same cycle becomes the new opcode.
  always_comb begin
    state_d   = state_q;
    take_opc  = 1'b0;
    take_data = 1'b0;
    complete  = 1'b0;
    if (rx_expire) begin
      take_opc = i_rx_valid;
      state_d  = i_rx_valid ? IDX_D3 : IDX_OPC;
    end else if (i_rx_valid) begin
      unique case (state_q)
        IDX_OPC: begin take_opc  = 1'b1; state_d = IDX_D3;  end
        IDX_D3:  begin take_data = 1'b1; state_d = IDX_D2;  end
        IDX_D2:  begin take_data = 1'b1; state_d = IDX_D1;  end
        IDX_D1:  begin take_data = 1'b1; state_d = IDX_D0;  end
        IDX_D0:  begin complete  = 1'b1; state_d = IDX_OPC; end
        default: state_d = IDX_OPC;
      endcase
    end
  end

  assign cmd_free = !cmd_valid_q || i_cmd_ready;

  // Byte capture, output register, valid handshake and status flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      opcode_q    <= '0;
      data_q      <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      busy_q <= (state_d != IDX_OPC);
      ovf_q  <= complete && !cmd_free;
      if (take_opc)  opcode_q <= i_rx_data[3:0];
      if (take_data) data_q   <= {data_q[15:0], i_rx_data};
      if (complete && cmd_free) begin
        cmd_q.opcode <= opcode_q;
        cmd_q.data   <= {data_q, i_rx_data};
        cmd_valid_q  <= 1'b1;
      end else if (cmd_valid_q && i_cmd_ready) begin
        cmd_valid_q  <= 1'b0;
      end
    end
  end

  assign o_cmd       = cmd_q;
  assign o_cmd_valid = cmd_valid_q;
  assign o_busy      = busy_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_wbdbgbus_cmd_assembler.sv
// Directed bench for wbdbgbus_cmd_assembler: a per-cycle vector table for
// assembly, back-pressure and hand-off, plus hand sequences for gap timeout
// and reset. Timeout sequences follow WBDBGBUS_CMD_TIMEOUT_EN.
module tb_wbdbgbus_cmd_assembler;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic [35:0] o_cmd;
  logic        o_cmd_valid;
  logic        i_cmd_ready;
  logic        o_busy;
  logic        o_overflow;
  logic        o_timeout;

  int checks   = 0;
  int failures = 0;

  wbdbgbus_cmd_assembler #(
    .TIMEOUT_CLKS (50)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .o_cmd       (o_cmd),
    .o_cmd_valid (o_cmd_valid),
    .i_cmd_ready (i_cmd_ready),
    .o_busy      (o_busy),
    .o_overflow  (o_overflow),
    .o_timeout   (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        r;
    logic        ev;
    logic [35:0] ec;
    logic        eb;
    logic        eo;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic v, input logic [7:0] d, input logic r,
                              input logic ev, input logic [35:0] ec,
                              input logic eb, input logic eo);
    vec_t x;
    x.v = v; x.d = d; x.r = r; x.ev = ev; x.ec = ec; x.eb = eb; x.eo = eo;
    vecs.push_back(x);
  endfunction

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Apply inputs on the falling edge, then look at outputs just after the rise.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    @(negedge i_clk);
    i_rx_valid  = v;
    i_rx_data   = d;
    i_cmd_ready = r;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n, input logic r, input logic chk_busy);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 8'h00, r);
      if (chk_busy) begin
        chk($sformatf("idle%0d_busy", k), 36'(o_busy), 36'd1);
        chk($sformatf("idle%0d_timeout", k), 36'(o_timeout), 36'd0);
      end
    end
  endtask

  initial begin
    i_rst = 1'b1; i_rx_valid = 1'b0; i_rx_data = 8'h00; i_cmd_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("rst_cmd", o_cmd, 36'h0);
    chk("rst_valid", 36'(o_cmd_valid), 36'd0);
    chk("rst_busy", 36'(o_busy), 36'd0);
    chk("rst_ovf", 36'(o_overflow), 36'd0);
    chk("rst_to", 36'(o_timeout), 36'd0);
    i_rst = 1'b0;

    // Basic assembly with ready held high; upper opcode nibble ignored.
    add(1, 8'h31, 1, 0, 36'h0,         1, 0);
    add(1, 8'hDE, 1, 0, 36'h0,         1, 0);
    add(1, 8'hAD, 1, 0, 36'h0,         1, 0);
    add(1, 8'hBE, 1, 0, 36'h0,         1, 0);
    add(1, 8'hEF, 1, 1, 36'h1_DEADBEEF, 0, 0);
    add(0, 8'h00, 1, 0, 36'h0,         0, 0);
    // Back-pressure: second command dropped, first held, one overflow pulse.
    add(1, 8'h02, 0, 0, 36'h0,         1, 0);
    add(1, 8'h00, 0, 0, 36'h0,         1, 0);
    add(1, 8'h00, 0, 0, 36'h0,         1, 0);
    add(1, 8'h00, 0, 0, 36'h0,         1, 0);
    add(1, 8'h01, 0, 1, 36'h2_00000001, 0, 0);
    add(1, 8'h03, 0, 1, 36'h2_00000001, 1, 0);
    add(1, 8'h00, 0, 1, 36'h2_00000001, 1, 0);
    add(1, 8'h00, 0, 1, 36'h2_00000001, 1, 0);
    add(1, 8'h00, 0, 1, 36'h2_00000001, 1, 0);
    add(1, 8'h02, 0, 1, 36'h2_00000001, 0, 1);
    add(0, 8'h00, 0, 1, 36'h2_00000001, 0, 0);
    add(0, 8'h00, 1, 0, 36'h0,         0, 0);
    add(0, 8'h00, 1, 0, 36'h0,         0, 0);
    // Hold A, then transfer A in the same cycle B completes.
    add(1, 8'h04, 0, 0, 36'h0,         1, 0);
    add(1, 8'h00, 0, 0, 36'h0,         1, 0);
    add(1, 8'h00, 0, 0, 36'h0,         1, 0);
    add(1, 8'h00, 0, 0, 36'h0,         1, 0);
    add(1, 8'hAA, 0, 1, 36'h4_000000AA, 0, 0);
    add(1, 8'h05, 0, 1, 36'h4_000000AA, 1, 0);
    add(1, 8'h11, 0, 1, 36'h4_000000AA, 1, 0);
    add(1, 8'h22, 0, 1, 36'h4_000000AA, 1, 0);
    add(1, 8'h33, 0, 1, 36'h4_000000AA, 1, 0);
    add(1, 8'h44, 1, 1, 36'h5_11223344, 0, 0);
    add(0, 8'h00, 1, 0, 36'h0,         0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d, vecs[i].r);
      chk($sformatf("v%0d_valid", i), 36'(o_cmd_valid), 36'(vecs[i].ev));
      if (vecs[i].ev) chk($sformatf("v%0d_cmd", i), o_cmd, vecs[i].ec);
      chk($sformatf("v%0d_busy", i), 36'(o_busy), 36'(vecs[i].eb));
      chk($sformatf("v%0d_ovf", i), 36'(o_overflow), 36'(vecs[i].eo));
      chk($sformatf("v%0d_to", i), 36'(o_timeout), 36'd0);
    end

`ifdef WBDBGBUS_CMD_TIMEOUT_EN
    // Quiet line after two bytes: discard on the 50th idle cycle.
    step(1, 8'h05, 1);
    step(1, 8'h11, 1);
    idle(49, 1'b1, 1'b1);
    step(0, 8'h00, 1);
    chk("to_pulse", 36'(o_timeout), 36'd1);
    chk("to_busy", 36'(o_busy), 36'd0);
    step(0, 8'h00, 1);
    chk("to_pulse_end", 36'(o_timeout), 36'd0);
    step(1, 8'h06, 1); step(1, 8'h00, 1); step(1, 8'h00, 1); step(1, 8'h00, 1);
    step(1, 8'h07, 1);
    chk("to_next_valid", 36'(o_cmd_valid), 36'd1);
    chk("to_next_cmd", o_cmd, 36'h6_00000007);
    step(0, 8'h00, 1);

    // Byte arriving in the expiry cycle starts the next command.
    step(1, 8'h05, 1);
    idle(49, 1'b1, 1'b1);
    step(1, 8'h09, 1);
    chk("col_to", 36'(o_timeout), 36'd1);
    chk("col_busy", 36'(o_busy), 36'd1);
    step(1, 8'h01, 1); step(1, 8'h02, 1); step(1, 8'h03, 1);
    chk("col_busy3", 36'(o_busy), 36'd1);
    step(1, 8'h04, 1);
    chk("col_valid", 36'(o_cmd_valid), 36'd1);
    chk("col_cmd", o_cmd, 36'h9_01020304);
    chk("col_to_end", 36'(o_timeout), 36'd0);
    step(0, 8'h00, 1);
`else
    // Without the timer a partial command waits indefinitely.
    step(1, 8'h05, 1);
    step(1, 8'h11, 1);
    idle(60, 1'b1, 1'b1);
    step(1, 8'h22, 1); step(1, 8'h33, 1); step(1, 8'h44, 1);
    chk("nto_valid", 36'(o_cmd_valid), 36'd1);
    chk("nto_cmd", o_cmd, 36'h5_11223344);
    chk("nto_busy", 36'(o_busy), 36'd0);
    step(0, 8'h00, 1);
`endif

    // Reset mid-command with a command also held on the output.
    step(1, 8'h0B, 0); step(1, 8'h00, 0); step(1, 8'h00, 0); step(1, 8'h00, 0);
    step(1, 8'h01, 0);
    chk("mr_held", 36'(o_cmd_valid), 36'd1);
    step(1, 8'h0C, 0); step(1, 8'h01, 0); step(1, 8'h02, 0);
    chk("mr_busy", 36'(o_busy), 36'd1);
    @(negedge i_clk);
    i_rx_valid = 1'b0;
    i_rst = 1'b1;
    #1;
    chk("mr_cmd", o_cmd, 36'h0);
    chk("mr_valid", 36'(o_cmd_valid), 36'd0);
    chk("mr_busy0", 36'(o_busy), 36'd0);
    chk("mr_ovf", 36'(o_overflow), 36'd0);
    chk("mr_to", 36'(o_timeout), 36'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    step(1, 8'h0A, 1);
    chk("mr_b0_busy", 36'(o_busy), 36'd1);
    step(1, 8'h12, 1); step(1, 8'h34, 1); step(1, 8'h56, 1);
    chk("mr_b3_valid", 36'(o_cmd_valid), 36'd0);
    step(1, 8'h78, 1);
    chk("mr_new_valid", 36'(o_cmd_valid), 36'd1);
    chk("mr_new_cmd", o_cmd, 36'hA_12345678);
    step(0, 8'h00, 1);
    chk("mr_drop", 36'(o_cmd_valid), 36'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
